// File: rtl/blink_sequencer_if.sv
// ----------------------------------------------------------------------------
// blink_sequencer_if
//   Bundles the control, table-programming and status signals of the blink
//   step sequencer. clk and rst_n stay plain module ports.
//
//   Signals (direction given from the sequencer's point of view):
//     current_count  in   16               free-running count from the counter block
//     cfg_we         in   1                table write strobe (one cycle)
//     cfg_addr       in   SW               table entry address
//     cfg_data       in   NUM_LANES+DUR_W  {mask, duration}
//     last_step      in   SW               final step index, latched on start
//     start          in   1                begin sequence (level, IDLE only)
//     stop           in   1                abort to IDLE
//     pause          in   1                freeze the countdown while high
//     lane_en        out  NUM_LANES        registered lane enables
//     step_idx       out  SW               current step index
//     busy           out  1                high while a sequence runs
//     step_pulse     out  1                one-cycle pulse on each step advance
//     done           out  1                one-cycle pulse on sequence end
//
//   Modports:
//     master - the controller side (drives configuration and control)
//     slave  - the sequencer side
// ----------------------------------------------------------------------------
interface blink_sequencer_if #(
    parameter int NUM_LANES = 4,
    parameter int NUM_STEPS = 8,
    parameter int DUR_W     = 4
);
    localparam int SW      = $clog2(NUM_STEPS);
    localparam int ENTRY_W = NUM_LANES + DUR_W;

    logic [15:0]          current_count;
    logic                 cfg_we;
    logic [SW-1:0]        cfg_addr;
    logic [ENTRY_W-1:0]   cfg_data;
    logic [SW-1:0]        last_step;
    logic                 start;
    logic                 stop;
    logic                 pause;
    logic [NUM_LANES-1:0] lane_en;
    logic [SW-1:0]        step_idx;
    logic                 busy;
    logic                 step_pulse;
    logic                 done;

    modport master (
        output current_count, cfg_we, cfg_addr, cfg_data, last_step,
               start, stop, pause,
        input  lane_en, step_idx, busy, step_pulse, done
    );

    modport slave (
        input  current_count, cfg_we, cfg_addr, cfg_data, last_step,
               start, stop, pause,
        output lane_en, step_idx, busy, step_pulse, done
    );
endinterface

// File: rtl/blink_sequencer.sv
// ----------------------------------------------------------------------------
// blink_sequencer
//   Steps through a small software-loaded table of {lane mask, duration}
//   entries, timing each step in ticks derived from one bit of the shared
//   free-running counter, and drives per-lane enables that gate the blinker
//   outputs at the top level.
//
//   Ports:
//     clk    in   system clock
//     rst_n  in   asynchronous active-low reset
//     bus    slave modport of blink_sequencer_if (control, table writes,
//            lane enables and status; see the interface header)
//
//   Parameters:
//     NUM_LANES  number of gated lanes (lane_en / mask width)
//     NUM_STEPS  table depth, power of two
//     TICK_BIT   counter bit whose rising edge is one tick
//     DUR_W      duration field width; a field value of 0 means 2**DUR_W ticks
//
//   Build option:
//     BLINK_SEQ_LOOP_EN  when defined, finishing the last step restarts at
//                        step 0 (done and step_pulse together) and the block
//                        stays in RUN until stop; when undefined, finishing
//                        the last step returns to IDLE with a done pulse.
// ----------------------------------------------------------------------------
module blink_sequencer #(
    parameter int NUM_LANES = 4,
    parameter int NUM_STEPS = 8,
    parameter int TICK_BIT  = 10,
    parameter int DUR_W     = 4
) (
    input logic              clk,
    input logic              rst_n,
    blink_sequencer_if.slave bus
);
    localparam int SW      = $clog2(NUM_STEPS);
    localparam int ENTRY_W = NUM_LANES + DUR_W;

    localparam logic [DUR_W:0] REM_ONE  = (DUR_W + 1)'(1);
    localparam logic [DUR_W:0] REM_FULL = {1'b1, {DUR_W{1'b0}}};

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t               state_reg;
    logic                 tick_prev_reg;
    logic [DUR_W:0]       remaining_reg;
    logic [SW-1:0]        last_step_reg;
    logic [NUM_LANES-1:0] lane_en_reg;
    logic [SW-1:0]        step_idx_reg;
    logic                 busy_reg;
    logic                 step_pulse_reg;
    logic                 done_reg;

    // Step table. Not reset: software reloads it after power-up.
    logic [ENTRY_W-1:0] table_mem [NUM_STEPS];

    // Only TICK_BIT of the counter is of interest here.
    logic unused_count_bits;
    assign unused_count_bits = ^bus.current_count;

    // ------------------------------------------------------------------
    // Tick detection: one-cycle strobe on the rising edge of TICK_BIT.
    // ------------------------------------------------------------------
    logic tick;
    assign tick = bus.current_count[TICK_BIT] & ~tick_prev_reg;

    // ------------------------------------------------------------------
    // Table write port, active in any state. The entry is only read when
    // its step is loaded, so rewriting the running step changes nothing
    // until that step is loaded again.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (bus.cfg_we) begin
            table_mem[bus.cfg_addr] <= bus.cfg_data;
        end
    end

    // ------------------------------------------------------------------
    // Entry about to be loaded. From IDLE, and when wrapping at the last
    // step, that is entry 0; otherwise it is the step after the current
    // one. Read combinationally so the loaded step appears the cycle
    // after the triggering edge.
    // ------------------------------------------------------------------
    logic [SW-1:0]        next_idx;
    logic                 at_last;
    logic [SW-1:0]        load_idx;
    logic [ENTRY_W-1:0]   load_entry;
    logic [NUM_LANES-1:0] load_mask;
    logic [DUR_W-1:0]     load_field;
    logic [DUR_W:0]       load_dur;

    assign next_idx = step_idx_reg + SW'(1);
    assign at_last  = (step_idx_reg == last_step_reg);

    always_comb begin
        load_idx = '0;
        if (state_reg == RUN && !at_last) begin
            load_idx = next_idx;
        end
        load_entry = table_mem[load_idx];
        load_mask  = load_entry[ENTRY_W-1:DUR_W];
        load_field = load_entry[DUR_W-1:0];
        // A zero duration field encodes the longest step, 2**DUR_W ticks.
        load_dur = {1'b0, load_field};
        if (load_field == '0) begin
            load_dur = REM_FULL;
        end
    end

    // ------------------------------------------------------------------
    // Sequencer FSM with registered outputs.
    // remaining_reg counts ticks left in the current step; the step ends
    // on the tick that finds it at 1. The first tick after a load may come
    // early in the step, so step length is measured tick to tick.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            tick_prev_reg  <= 1'b0;
            remaining_reg  <= '0;
            last_step_reg  <= '0;
            lane_en_reg    <= '0;
            step_idx_reg   <= '0;
            busy_reg       <= 1'b0;
            step_pulse_reg <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            tick_prev_reg  <= bus.current_count[TICK_BIT];
            step_pulse_reg <= 1'b0;
            done_reg       <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (bus.start && !bus.stop) begin
                        state_reg     <= RUN;
                        busy_reg      <= 1'b1;
                        step_idx_reg  <= '0;
                        lane_en_reg   <= load_mask;
                        remaining_reg <= load_dur;
                        last_step_reg <= bus.last_step;
                    end
                end

                RUN: begin
                    if (bus.stop) begin
                        // Abort: silent return to IDLE, no done pulse.
                        state_reg     <= IDLE;
                        busy_reg      <= 1'b0;
                        lane_en_reg   <= '0;
                        step_idx_reg  <= '0;
                        remaining_reg <= '0;
                    end else if (tick && !bus.pause) begin
                        // While paused, ticks are simply dropped.
                        if (remaining_reg == REM_ONE) begin
                            if (at_last) begin
`ifdef BLINK_SEQ_LOOP_EN
                                step_idx_reg   <= '0;
                                lane_en_reg    <= load_mask;
                                remaining_reg  <= load_dur;
                                step_pulse_reg <= 1'b1;
                                done_reg       <= 1'b1;
`else
                                state_reg     <= IDLE;
                                busy_reg      <= 1'b0;
                                lane_en_reg   <= '0;
                                step_idx_reg  <= '0;
                                remaining_reg <= '0;
                                done_reg      <= 1'b1;
`endif
                            end else begin
                                step_idx_reg   <= next_idx;
                                lane_en_reg    <= load_mask;
                                remaining_reg  <= load_dur;
                                step_pulse_reg <= 1'b1;
                            end
                        end else begin
                            remaining_reg <= remaining_reg - REM_ONE;
                        end
                    end
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.lane_en    = lane_en_reg;
    assign bus.step_idx   = step_idx_reg;
    assign bus.busy       = busy_reg;
    assign bus.step_pulse = step_pulse_reg;
    assign bus.done       = done_reg;

endmodule

// File: tb/tb_blink_sequencer.sv
// ----------------------------------------------------------------------------
// tb_blink_sequencer
//   Self-checking bench for blink_sequencer with TICK_BIT=2 (a tick every
//   8 clocks), DUR_W=4, NUM_LANES=4, NUM_STEPS=8. A reference model that
//   counts elapsed ticks against each loaded step's duration is compared
//   with the DUT every cycle; directed table-driven scenarios and
//   hand-written corner-case sequences add explicit checks.
//   Honours BLINK_SEQ_LOOP_EN the same way as the design.
// ----------------------------------------------------------------------------
module tb_blink_sequencer;
    localparam int NL       = 4;
    localparam int NS       = 8;
    localparam int TICK_BIT = 2;
    localparam int DW       = 4;
    localparam int SW       = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    blink_sequencer_if #(.NUM_LANES(NL), .NUM_STEPS(NS), .DUR_W(DW)) bus ();

    blink_sequencer #(
        .NUM_LANES(NL), .NUM_STEPS(NS), .TICK_BIT(TICK_BIT), .DUR_W(DW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    // ------------------------------------------------------------------
    // Reference model: tracks which step is active, the duration captured
    // when it was loaded, and how many unpaused ticks have elapsed in it.
    // ------------------------------------------------------------------
    bit        m_busy;
    int        m_idx, m_last, m_elapsed, m_dur;
    logic [3:0] m_lane;
    bit        m_pulse, m_done;
    logic      m_prev;
    logic [7:0] m_tbl [NS];

    bit last_run_tick;   // tick that counted toward a running step
    bit last_busy_tick;  // any tick while running (paused or not)

    function automatic int dur_of(input logic [3:0] d);
        return (d == 4'd0) ? 16 : int'(d);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_idx = 0; m_last = 0; m_elapsed = 0; m_dur = 0;
        m_lane = '0; m_pulse = 0; m_done = 0; m_prev = 1'b0;
    endtask

    task automatic model_load(input int i);
        m_idx     = i;
        m_lane    = m_tbl[i][7:4];
        m_dur     = dur_of(m_tbl[i][3:0]);
        m_elapsed = 0;
    endtask

    // One clock: model follows the edge, DUT is compared 1 time unit later,
    // then the free-running counter advances.
    task automatic cycle();
        logic tk;
        bit   was_busy;
        @(posedge clk);
        tk = bus.current_count[TICK_BIT] & ~m_prev;
        was_busy = m_busy;
        last_run_tick  = 0;
        last_busy_tick = 0;
        m_pulse = 0;
        m_done  = 0;
        if (!rst_n) begin
            model_reset();
        end else begin
            m_prev = bus.current_count[TICK_BIT];
            last_busy_tick = was_busy && tk && !bus.stop;
            last_run_tick  = last_busy_tick && !bus.pause;
            if (!m_busy) begin
                if (bus.start && !bus.stop) begin
                    m_busy = 1;
                    m_last = int'(bus.last_step);
                    model_load(0);
                end
            end else if (bus.stop) begin
                m_busy = 0; m_idx = 0; m_lane = '0;
            end else if (tk && !bus.pause) begin
                m_elapsed++;
                if (m_elapsed >= m_dur) begin
                    if (m_idx == m_last) begin
                        m_done = 1;
`ifdef BLINK_SEQ_LOOP_EN
                        m_pulse = 1;
                        model_load(0);
`else
                        m_busy = 0; m_idx = 0; m_lane = '0;
`endif
                    end else begin
                        m_pulse = 1;
                        model_load(m_idx + 1);
                    end
                end
            end
        end
        // Writes land after the load above read the old contents.
        if (bus.cfg_we) m_tbl[bus.cfg_addr] = bus.cfg_data;
        #1;
        check("model_lane_en", bus.lane_en, m_lane);
        check("model_step_idx", bus.step_idx, m_idx[SW-1:0]);
        check("model_busy", bus.busy, m_busy);
        check("model_step_pulse", bus.step_pulse, m_pulse);
        check("model_done", bus.done, m_done);
        bus.current_count = bus.current_count + 16'd1;
    endtask

    task automatic write_entry(input int addr, input logic [3:0] mask, input logic [3:0] dur);
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = SW'(addr);
        bus.cfg_data = {mask, dur};
        cycle();
        bus.cfg_we   = 1'b0;
    endtask

    task automatic stop_now();
        bus.start = 1'b0;
        bus.stop  = 1'b1;
        cycle();
        bus.stop  = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Table-driven scenarios: four entries (nibble i = step i) and the
    // expected tick total and number of mid-sequence step advances.
    // ------------------------------------------------------------------
    typedef struct {
        logic [15:0] masks;
        logic [15:0] durs;
        int          last;
        int          exp_ticks;
        int          exp_pulses;
    } scen_t;

    scen_t scen [5];

    initial begin
        logic [15:0] mk, dr;
        int ticks, pulses, cum;
        bit got_done;

        scen[0] = '{masks: 16'h00A1, durs: 16'h0012, last: 1, exp_ticks: 3,  exp_pulses: 1};
        scen[1] = '{masks: 16'h0003, durs: 16'h0000, last: 0, exp_ticks: 16, exp_pulses: 0};
        scen[2] = '{masks: 16'h842F, durs: 16'h2135, last: 3, exp_ticks: 11, exp_pulses: 3};
        scen[3] = '{masks: 16'h0008, durs: 16'h0001, last: 0, exp_ticks: 1,  exp_pulses: 0};
        scen[4] = '{masks: 16'h0C53, durs: 16'h0101, last: 2, exp_ticks: 18, exp_pulses: 2};

        bus.current_count = 16'd0;
        bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_data = '0;
        bus.last_step = '0; bus.start = 1'b0; bus.stop = 1'b0; bus.pause = 1'b0;
        model_reset();
        for (int i = 0; i < NS; i++) m_tbl[i] = 8'h00;

        // ---- 1. reset values, then idle without start ----
        repeat (3) cycle();
        check("reset_lane_en", bus.lane_en, 0);
        check("reset_step_idx", bus.step_idx, 0);
        check("reset_busy", bus.busy, 0);
        check("reset_done", bus.done, 0);
        rst_n = 1'b1;
        for (int i = 0; i < NS; i++) write_entry(i, 4'h0, 4'h1);
        repeat (20) cycle();
        check("idle_no_start_busy", bus.busy, 0);
        check("idle_no_start_lane", bus.lane_en, 0);

        // ---- 2/3. table-driven scenarios ----
        for (int s = 0; s < 5; s++) begin
            mk = scen[s].masks;
            dr = scen[s].durs;
            for (int i = 0; i < 4; i++) write_entry(i, mk[4*i +: 4], dr[4*i +: 4]);
            bus.last_step = SW'(scen[s].last);
            bus.start = 1'b1;
            cycle();
            bus.start = 1'b0;
            check("scen_first_lane", bus.lane_en, mk[3:0]);
            check("scen_busy_after_start", bus.busy, 1);
            ticks = 0; pulses = 0; got_done = 0;
            cum = dur_of(dr[3:0]);
            for (int c = 0; c < 400 && !got_done; c++) begin
                cycle();
                if (last_run_tick) ticks++;
                if (bus.done) begin
                    got_done = 1;
                end else if (bus.step_pulse) begin
                    pulses++;
                    check("scen_ticks_at_advance", ticks, cum);
                    check("scen_step_lane", bus.lane_en, mk[4*pulses +: 4]);
                    cum += dur_of(dr[4*pulses +: 4]);
                end
            end
            check("scen_done_seen", got_done, 1);
            check("scen_total_ticks", ticks, scen[s].exp_ticks);
            check("scen_advances", pulses, scen[s].exp_pulses);
`ifdef BLINK_SEQ_LOOP_EN
            check("scen_end_busy", bus.busy, 1);
            check("scen_end_lane", bus.lane_en, mk[3:0]);
            check("scen_end_pulse", bus.step_pulse, 1);
`else
            check("scen_end_busy", bus.busy, 0);
            check("scen_end_lane", bus.lane_en, 0);
            check("scen_end_pulse", bus.step_pulse, 0);
`endif
            check("scen_end_idx", bus.step_idx, 0);
            stop_now();
        end

        // ---- 4. pause for 3 ticks mid-step ----
        write_entry(0, 4'h6, 4'd4);
        bus.last_step = '0;
        bus.start = 1'b1; cycle(); bus.start = 1'b0;
        ticks = 0; got_done = 0;
        for (int c = 0; c < 300 && !got_done; c++) begin
            cycle();
            if (last_busy_tick) ticks++;
            if (bus.done) got_done = 1;
            else if (bus.pause) check("pause_lane_held", bus.lane_en, 4'h6);
            if (ticks == 1) bus.pause = 1'b1;
            if (ticks == 4) bus.pause = 1'b0;
        end
        bus.pause = 1'b0;
        check("pause_done_seen", got_done, 1);
        check("pause_total_ticks", ticks, 7);
        stop_now();

        // ---- 5. stop with start high mid-step ----
        write_entry(0, 4'h9, 4'd5);
        bus.start = 1'b1; cycle(); bus.start = 1'b0;
        repeat (12) cycle();
        check("stop_pre_busy", bus.busy, 1);
        bus.start = 1'b1; bus.stop = 1'b1;
        cycle();
        bus.start = 1'b0; bus.stop = 1'b0;
        check("stop_busy", bus.busy, 0);
        check("stop_lane", bus.lane_en, 0);
        check("stop_done", bus.done, 0);
        check("stop_idx", bus.step_idx, 0);

        // ---- 6. rewrite of the active entry ----
        write_entry(0, 4'h1, 4'd3);
        bus.start = 1'b1; cycle(); bus.start = 1'b0;
        repeat (3) cycle();
        write_entry(0, 4'hF, 4'd3);
        got_done = 0;
        for (int c = 0; c < 200 && !got_done; c++) begin
            cycle();
            if (bus.done) got_done = 1;
            else check("rewrite_lane_held", bus.lane_en, 4'h1);
        end
        check("rewrite_done_seen", got_done, 1);
`ifndef BLINK_SEQ_LOOP_EN
        bus.start = 1'b1; cycle(); bus.start = 1'b0;
`endif
        check("rewrite_reload_lane", bus.lane_en, 4'hF);
        stop_now();

        // ---- randomized traffic against the model ----
        for (int i = 0; i < NS; i++) write_entry(i, 4'($urandom), 4'($urandom));
        for (int c = 0; c < 6000; c++) begin
            bus.cfg_we    = ($urandom_range(0, 7) == 0);
            bus.cfg_addr  = SW'($urandom);
            bus.cfg_data  = 8'($urandom);
            bus.last_step = SW'($urandom_range(0, 3));
            bus.start     = ($urandom_range(0, 3) == 0);
            bus.stop      = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 15) == 0) bus.pause = ~bus.pause;
            cycle();
        end
        bus.cfg_we = 1'b0; bus.stop = 1'b0; bus.pause = 1'b0;

        // ---- asynchronous reset mid-run ----
        write_entry(0, 4'hC, 4'd6);
        bus.last_step = '0;
        bus.start = 1'b1; cycle(); bus.start = 1'b0;
        repeat (5) cycle();
        check("areset_pre_busy", bus.busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("areset_lane", bus.lane_en, 0);
        check("areset_busy", bus.busy, 0);
        check("areset_idx", bus.step_idx, 0);
        repeat (2) cycle();
        rst_n = 1'b1;
        repeat (4) cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
